wave_generator_mc: RTL and testbench

- Parametrised multi-channel successor of the single-channel wave generator.
- NUM_CH independent DDS channels are processed time-multiplexed, one channel per clock, after each sample tick.
- Each channel has its own phase step, waveform mode, duty and gain; channel outputs are summed into one saturated sample.
- Sits between the sample-rate strobe generator and the audio/DAC output path, on a single system clock.

---
 rtl/wave_generator_mc.sv | 236 +++++++++++++++++++++++
 tb/tb_wave_generator_mc.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_generator_mc.sv
// wave_generator_mc: time-multiplexed multi-channel DDS wave generator.
//
// After each accepted sample tick the shadow configuration of every channel
// is committed to the active set. The channels are then evaluated one per
// clock (waveform, gain, accumulate), and the saturated sum is presented on
// o_wave_out together with a one-cycle o_valid pulse, NUM_CH+1 cycles after
// the tick.
//
// Ports:
//   i_clk, i_rst        system clock, synchronous active-high reset
//   i_sample_tick       one-cycle sample-rate strobe
//   i_cfg_we/ch/addr/data  shadow register write
//                       (0 step, 1 mode/duty, 2 gain, 3 phase load)
//   o_wave_out          signed mixed sample, held between frames
//   o_valid             one-cycle pulse when o_wave_out is updated
//   o_clip              pulses with o_valid when the sum saturated
//   o_busy              frame in progress
//   o_overrun           one-cycle pulse when a tick was dropped
//
// Optional feature: define WAVE_GEN_NOISE_EN to build the per-channel
// 16-bit Galois LFSRs used by mode 4 (noise). Without it mode 4 outputs 0.
module wave_generator_mc #(
  parameter int  NUM_CH  = 4,
  parameter int  PHASE_W = 24,
  parameter int  OUT_W   = 16,
  parameter int  GAIN_W  = 8,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_sample_tick,
  input  logic                    i_cfg_we,
  input  logic [CH_W-1:0]         i_cfg_ch,
  input  logic [1:0]              i_cfg_addr,
  input  logic [31:0]             i_cfg_data,
  output logic signed [OUT_W-1:0] o_wave_out,
  output logic                    o_valid,
  output logic                    o_clip,
  output logic                    o_busy,
  output logic                    o_overrun
);

  localparam int ACC_W = OUT_W + GAIN_W + CH_W + 1;
  localparam int PRD_W = OUT_W + GAIN_W + 1;

  localparam logic signed [OUT_W-1:0] MAX_S = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_S = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]        MSB_M = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-OUT_W){1'b0}}, MAX_S};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-OUT_W){1'b1}}, MIN_S};
  localparam logic [GAIN_W-1:0]       GAIN_UNITY = {1'b1, {(GAIN_W-1){1'b0}}};
  localparam logic [CH_W-1:0]         LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic signed [OUT_W-1:0] wave_sample(
    input logic [2:0]              mode,
    input logic [OUT_W-1:0]        p,
    input logic [7:0]              duty,
    input logic signed [OUT_W-1:0] noise
  );
    logic [OUT_W-1:0] t;
    t = p[OUT_W-1] ? ~(p << 1) : (p << 1);
    case (mode)
      3'd1:    wave_sample = p ^ MSB_M;
      3'd2:    wave_sample = (p[OUT_W-1 -: 8] < duty) ? MAX_S : -MAX_S;
      3'd3:    wave_sample = t ^ MSB_M;
      3'd4:    wave_sample = noise;
      3'd5:    wave_sample = MAX_S;
      default: wave_sample = '0;
    endcase
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
    if (a > ACC_MAX)      sat_out = MAX_S;
    else if (a < ACC_MIN) sat_out = MIN_S;
    else                  sat_out = a[OUT_W-1:0];
  endfunction

  function automatic logic is_clip(input logic signed [ACC_W-1:0] a);
    is_clip = (a > ACC_MAX) || (a < ACC_MIN);
  endfunction

  // Shadow (written any cycle) and active (committed at tick) configuration
  logic [PHASE_W-1:0] step_sh_q [NUM_CH];
  logic [2:0]         mode_sh_q [NUM_CH];
  logic [7:0]         duty_sh_q [NUM_CH];
  logic [GAIN_W-1:0]  gain_sh_q [NUM_CH];
  logic               pld_pend_q [NUM_CH];
  logic [PHASE_W-1:0] pld_val_q [NUM_CH];

  logic [PHASE_W-1:0] step_q  [NUM_CH];
  logic [2:0]         mode_q  [NUM_CH];
  logic [7:0]         duty_q  [NUM_CH];
  logic [GAIN_W-1:0]  gain_q  [NUM_CH];
  logic [PHASE_W-1:0] phase_q [NUM_CH];

  state_t                  state_q;
  logic [CH_W-1:0]         ch_q;
  logic signed [ACC_W-1:0] acc_q;

  logic [OUT_W-1:0]        p_cur;
  logic signed [OUT_W-1:0] noise_s;
  logic signed [OUT_W-1:0] s_cur;
  logic signed [PRD_W-1:0] s_ext;
  logic signed [PRD_W-1:0] g_ext;
  logic signed [PRD_W-1:0] prod;
  logic signed [PRD_W-1:0] prod_sh;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_d;
  logic                    cfg_data_unused;

  assign cfg_data_unused = ^i_cfg_data;
  assign p_cur = phase_q[ch_q][PHASE_W-1 -: OUT_W];

`ifdef WAVE_GEN_NOISE_EN
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    lfsr_next = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  logic [15:0] lfsr_q [NUM_CH];
  logic [15:0] lfsr_cur;
  assign lfsr_cur = lfsr_q[ch_q];

  if (OUT_W <= 16) begin : g_noise_narrow
    assign noise_s = lfsr_cur[OUT_W-1:0];
  end else begin : g_noise_wide
    assign noise_s = {{(OUT_W-16){1'b0}}, lfsr_cur};
  end

  // Every LFSR steps once per frame, after its value has been used
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) lfsr_q[c] <= 16'hACE1 ^ 16'(c);
    end else if (state_q == DONE) begin
      for (int c = 0; c < NUM_CH; c++) lfsr_q[c] <= lfsr_next(lfsr_q[c]);
    end
  end
`else
  assign noise_s = '0;
`endif

  // Per-channel datapath: sample from pre-advance phase, scale, accumulate
  always_comb begin
    s_cur   = wave_sample(mode_q[ch_q], p_cur, duty_q[ch_q], noise_s);
    s_ext   = {{(GAIN_W+1){s_cur[OUT_W-1]}}, s_cur};
    g_ext   = {{OUT_W{1'b0}}, 1'b0, gain_q[ch_q]};
    prod    = s_ext * g_ext;
    prod_sh = prod >>> (GAIN_W - 1);
    term    = {{(ACC_W-PRD_W){prod_sh[PRD_W-1]}}, prod_sh};
    acc_d   = acc_q + term;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      acc_q      <= '0;
      o_wave_out <= '0;
      o_valid    <= 1'b0;
      o_clip     <= 1'b0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        step_sh_q[c]  <= '0;
        mode_sh_q[c]  <= 3'd0;
        duty_sh_q[c]  <= 8'd128;
        gain_sh_q[c]  <= GAIN_UNITY;
        pld_pend_q[c] <= 1'b0;
        pld_val_q[c]  <= '0;
        step_q[c]     <= '0;
        mode_q[c]     <= 3'd0;
        duty_q[c]     <= 8'd128;
        gain_q[c]     <= GAIN_UNITY;
        phase_q[c]    <= '0;
      end
    end else begin
      o_valid   <= 1'b0;
      o_clip    <= 1'b0;
      o_overrun <= i_sample_tick && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (i_sample_tick) begin
            for (int c = 0; c < NUM_CH; c++) begin
              step_q[c]     <= step_sh_q[c];
              mode_q[c]     <= mode_sh_q[c];
              duty_q[c]     <= duty_sh_q[c];
              gain_q[c]     <= gain_sh_q[c];
              pld_pend_q[c] <= 1'b0;
              if (pld_pend_q[c]) phase_q[c] <= pld_val_q[c];
            end
            acc_q   <= '0;
            ch_q    <= '0;
            o_busy  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          phase_q[ch_q] <= phase_q[ch_q] + step_q[ch_q];
          acc_q         <= acc_d;
          ch_q          <= ch_q + CH_W'(1);
          if (ch_q == LAST_CH) begin
            o_wave_out <= sat_out(acc_d);
            o_clip     <= is_clip(acc_d);
            o_valid    <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          o_busy  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Writes come after the commit so a phase load armed in the tick
      // cycle stays pending for the next frame.
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_cfg_we && (i_cfg_ch == CH_W'(c))) begin
          case (i_cfg_addr)
            2'd0: step_sh_q[c] <= i_cfg_data[PHASE_W-1:0];
            2'd1: begin
              mode_sh_q[c] <= i_cfg_data[2:0];
              duty_sh_q[c] <= i_cfg_data[15:8];
            end
            2'd2: gain_sh_q[c] <= i_cfg_data[GAIN_W-1:0];
            default: begin
              pld_pend_q[c] <= 1'b1;
              pld_val_q[c]  <= i_cfg_data[PHASE_W-1:0];
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_generator_mc.sv
module tb_wave_generator_mc;
  localparam int NUM_CH  = 4;
  localparam int PHASE_W = 24;
  localparam int OUT_W   = 16;
  localparam int GAIN_W  = 8;
  localparam int CH_W    = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    tick = 1'b0;
  logic                    we = 1'b0;
  logic [CH_W-1:0]         cfg_ch = '0;
  logic [1:0]              cfg_addr = '0;
  logic [31:0]             cfg_data = '0;
  logic signed [OUT_W-1:0] wave;
  logic                    valid, clip, busy, ovr;

  always #5 clk = ~clk;

  wave_generator_mc #(
    .NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sample_tick(tick),
    .i_cfg_we(we), .i_cfg_ch(cfg_ch), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .o_wave_out(wave), .o_valid(valid), .o_clip(clip), .o_busy(busy), .o_overrun(ovr)
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    valid_cnt = 0;
  int    ovr_cnt = 0;
  string cur_test = "reset";

  typedef struct {
    logic signed [15:0] wave;
    logic               clip;
    int                 due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]         mode;
    logic [7:0]         duty;
    logic [7:0]         gain;
    logic [23:0]        phase;
    logic signed [15:0] wave;
    logic               clip;
  } vec_t;
  localparam int NV = 21;
  vec_t vt [NV];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d, expected %0d (cycle %0d)", cur_test, name, act, exp, cyc);
    end
  endtask

  // Output monitor: every o_valid must match the oldest outstanding frame
  always @(negedge clk) begin
    exp_t e;
    if (ovr) ovr_cnt++;
    if (valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s/unexpected_valid: o_valid with no frame outstanding, wave %0d (cycle %0d)",
                 cur_test, wave, cyc);
      end else begin
        e = sb.pop_front();
        chk("wave", wave, e.wave);
        chk("clip", clip, e.clip);
        chk("latency_cycle", cyc, e.due);
      end
    end
  end

  task automatic push_exp(input logic signed [15:0] w, input logic c);
    exp_t e;
    e.wave = w;
    e.clip = c;
    e.due  = cyc + NUM_CH + 1;
    sb.push_back(e);
  endtask

  task automatic do_tick(input logic signed [15:0] w, input logic c);
    @(negedge clk);
    tick = 1'b1;
    push_exp(w, c);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic cfg(input int ch, input int addr, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    cfg_ch = CH_W'(ch);
    cfg_addr = 2'(addr);
    cfg_data = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s/timeout: got %0d frames outstanding, expected 0", cur_test, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ev;
    int v0, o0;

    //        mode  duty    gain    phase      wave      clip
    vt[0]  = '{3'd1, 8'd0,   8'd128, 24'h000000, 16'h8000, 1'b0};
    vt[1]  = '{3'd1, 8'd0,   8'd128, 24'h800000, 16'h0000, 1'b0};
    vt[2]  = '{3'd1, 8'd0,   8'd128, 24'h400000, 16'hC000, 1'b0};
    vt[3]  = '{3'd1, 8'd0,   8'd128, 24'h123456, 16'h9234, 1'b0};
    vt[4]  = '{3'd1, 8'd0,   8'd64,  24'h000000, 16'hC000, 1'b0};
    vt[5]  = '{3'd1, 8'd0,   8'd255, 24'h000000, 16'h8000, 1'b1};
    vt[6]  = '{3'd2, 8'd128, 8'd128, 24'h000000, 16'h7FFF, 1'b0};
    vt[7]  = '{3'd2, 8'd128, 8'd128, 24'h800000, 16'h8001, 1'b0};
    vt[8]  = '{3'd2, 8'd0,   8'd128, 24'h000000, 16'h8001, 1'b0};
    vt[9]  = '{3'd2, 8'd255, 8'd128, 24'hFF0000, 16'h8001, 1'b0};
    vt[10] = '{3'd2, 8'd255, 8'd128, 24'hFE0000, 16'h7FFF, 1'b0};
    vt[11] = '{3'd3, 8'd0,   8'd128, 24'h000000, 16'h8000, 1'b0};
    vt[12] = '{3'd3, 8'd0,   8'd128, 24'h400000, 16'h0000, 1'b0};
    vt[13] = '{3'd3, 8'd0,   8'd128, 24'h800000, 16'h7FFF, 1'b0};
    vt[14] = '{3'd3, 8'd0,   8'd128, 24'hC00000, 16'hFFFF, 1'b0};
    vt[15] = '{3'd5, 8'd0,   8'd128, 24'h000000, 16'h7FFF, 1'b0};
    vt[16] = '{3'd5, 8'd0,   8'd64,  24'h000000, 16'h3FFF, 1'b0};
    vt[17] = '{3'd5, 8'd0,   8'd255, 24'h000000, 16'h7FFF, 1'b1};
    vt[18] = '{3'd5, 8'd0,   8'd0,   24'h000000, 16'h0000, 1'b0};
    vt[19] = '{3'd6, 8'd0,   8'd128, 24'h800000, 16'h0000, 1'b0};
    vt[20] = '{3'd0, 8'd0,   8'd128, 24'h800000, 16'h0000, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("wave", wave, 0);
    chk("valid", valid, 0);
    chk("clip", clip, 0);
    chk("busy", busy, 0);
    chk("overrun", ovr, 0);

    // All channels off: busy window and output latency
    cur_test = "all_off";
    @(negedge clk);
    tick = 1'b1;
    push_exp(16'h0000, 1'b0);
    chk("busy_c0", busy, 0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      tick = 1'b0;
      chk($sformatf("busy_c%0d", i), busy, (i <= 5) ? 1 : 0);
    end
    wait_done();

    // Single-frame vectors on ch0, step 0, other channels off
    for (int i = 0; i < NV; i++) begin
      cur_test = $sformatf("vec%0d", i);
      cfg(0, 1, {16'd0, vt[i].duty, 5'd0, vt[i].mode});
      cfg(0, 2, {24'd0, vt[i].gain});
      cfg(0, 0, 32'd0);
      cfg(0, 3, {8'd0, vt[i].phase});
      do_tick(vt[i].wave, vt[i].clip);
      wait_done();
    end

    // Saw sweep, wraps after 16 frames
    cur_test = "saw_sweep";
    cfg(0, 1, {16'd0, 8'd128, 5'd0, 3'd1});
    cfg(0, 2, 32'd128);
    cfg(0, 0, 32'h00100000);
    cfg(0, 3, 32'd0);
    for (int k = 0; k <= 16; k++) begin
      ev = 16'((k % 16) * 4096) ^ 16'h8000;
      do_tick($signed(ev), 1'b0);
      wait_done();
    end

    // Square duty 64 sweep
    cur_test = "square_sweep";
    cfg(0, 1, {16'd0, 8'd64, 5'd0, 3'd2});
    cfg(0, 3, 32'd0);
    for (int k = 0; k < 20; k++) begin
      do_tick(((k % 16) < 4) ? 16'sh7FFF : 16'sh8001, 1'b0);
      wait_done();
    end

    // Step written during RUN only applies from the next frame
    cur_test = "step_in_run";
    cfg(0, 1, {16'd0, 8'd128, 5'd0, 3'd1});
    cfg(0, 0, 32'h00100000);
    cfg(0, 3, 32'd0);
    @(negedge clk);
    tick = 1'b1;
    push_exp(16'h8000, 1'b0);
    @(negedge clk);
    tick = 1'b0;
    we = 1'b1; cfg_ch = 2'd0; cfg_addr = 2'd0; cfg_data = 32'h00200000;
    @(negedge clk);
    we = 1'b0;
    wait_done();
    do_tick(16'h9000, 1'b0);
    wait_done();
    do_tick(16'hB000, 1'b0);
    wait_done();

    // Gain write in the tick cycle commits one frame later
    cur_test = "tick_cycle_write";
    cfg(0, 1, {16'd0, 8'd128, 5'd0, 3'd5});
    cfg(0, 2, 32'd128);
    cfg(0, 0, 32'd0);
    @(negedge clk);
    tick = 1'b1;
    we = 1'b1; cfg_ch = 2'd0; cfg_addr = 2'd2; cfg_data = 32'd64;
    push_exp(16'h7FFF, 1'b0);
    @(negedge clk);
    tick = 1'b0;
    we = 1'b0;
    wait_done();
    do_tick(16'h3FFF, 1'b0);
    wait_done();

    // Multi-channel sums
    cur_test = "all_dc_clip";
    for (int c = 0; c < NUM_CH; c++) begin
      cfg(c, 1, {16'd0, 8'd128, 5'd0, 3'd5});
      cfg(c, 2, 32'd128);
      cfg(c, 0, 32'd0);
    end
    do_tick(16'h7FFF, 1'b1);
    wait_done();
    cur_test = "dc_plus_saw";
    cfg(1, 1, {16'd0, 8'd128, 5'd0, 3'd1});
    cfg(1, 3, 32'd0);
    cfg(2, 1, 32'd0);
    cfg(3, 1, 32'd0);
    do_tick(16'hFFFF, 1'b0);
    wait_done();

    // Second tick two cycles into a frame is dropped
    cur_test = "overrun";
    v0 = valid_cnt;
    o0 = ovr_cnt;
    @(negedge clk);
    tick = 1'b1;
    push_exp(16'hFFFF, 1'b0);
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    chk("overrun_pulses", ovr_cnt - o0, 1);
    chk("valid_count", valid_cnt - v0, 1);

    // Reset in the middle of a frame aborts it
    cur_test = "reset_mid_frame";
    v0 = valid_cnt;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("valid_after_abort", valid_cnt - v0, 0);
    chk("wave_after_reset", wave, 0);
    chk("busy_after_reset", busy, 0);

    // Noise on ch0, first frames after reset
    cur_test = "noise";
    cfg(0, 1, {16'd0, 8'd128, 5'd0, 3'd4});
`ifdef WAVE_GEN_NOISE_EN
    do_tick(16'hACE1, 1'b0);
    wait_done();
    do_tick(16'hE270, 1'b0);
    wait_done();
    do_tick(16'h7138, 1'b0);
    wait_done();
`else
    for (int k = 0; k < 3; k++) begin
      do_tick(16'h0000, 1'b0);
      wait_done();
    end
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
